serial_frame_ctrl: RTL

SERIAL_FRAME_CTRL -- requirements
Module: serial_frame_ctrl

---
 rtl/serial_frame_ctrl_pkg.sv | 16 +
 rtl/serial_frame_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/serial_frame_ctrl_pkg.sv
// serial_frame_ctrl_pkg
//   Shared constants and helpers for the serial frame controller.
//   SFC_WIDTH_DEF / SFC_GAP_DEF : default frame width and inter-frame gap
//   SFC_GAP_CW                  : gap counter width (covers GAP up to 15)
//   cnt_bits(n)                 : bits needed for a down-counter holding n-1
package serial_frame_ctrl_pkg;

    localparam int SFC_WIDTH_DEF = 8;
    localparam int SFC_GAP_DEF   = 2;
    localparam int SFC_GAP_CW    = 4;

    function automatic int cnt_bits(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_frame_ctrl.sv
// serial_frame_ctrl
//   Sequences an external PISO shift register: takes one sample through a
//   single-entry holding register, parallel-loads the PISO for one cycle,
//   strobes cs_n low for WIDTH shift cycles (MSB first), then holds cs_n high
//   for GAP idle cycles before the next frame may start.
//
//   Ports
//     clk        in   clock, rising edge
//     rst        in   synchronous active-high reset
//     en         in   allows a new frame to start from IDLE
//     s_data     in   [WIDTH] sample to serialize
//     s_valid    in   s_data valid
//     s_ready    out  holding register can accept a sample
//     sr_load    out  PISO LOAD (1 = parallel load, 0 = shift)
//     sr_pdata   out  [WIDTH] PISO parallel data
//     sr_si      out  PISO serial input, tied 0
//     cs_n       out  frame strobe, low while PISO SO carries frame bits
//     busy       out  controller not in IDLE
//     frame_done out  one-cycle pulse after the last shift cycle
//
//   state    | meaning
//   ---------+---------------------------------------------
//   ST_IDLE  | waiting for a held sample and en
//   ST_LOAD  | one cycle, PISO parallel load of hold_data
//   ST_SHIFT | WIDTH cycles, cs_n low, PISO shifting
//   ST_GAP   | GAP cycles, cs_n high before returning to IDLE
module serial_frame_ctrl
    import serial_frame_ctrl_pkg::*;
#(
    parameter int WIDTH = SFC_WIDTH_DEF,
    parameter int GAP   = SFC_GAP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             sr_load,
    output logic [WIDTH-1:0] sr_pdata,
    output logic             sr_si,
    output logic             cs_n,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = cnt_bits(WIDTH);
    localparam logic [SFC_GAP_CW-1:0] GAP_LOAD = SFC_GAP_CW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [WIDTH-1:0]      hold_data;
    logic                  hold_valid;
    logic [CW-1:0]         bit_cnt;
    logic [SFC_GAP_CW-1:0] gap_cnt;
    logic                  accept;

    // The holding register frees up during LOAD, so a new sample can be
    // taken in the same cycle the current one moves into the PISO.
    assign s_ready  = !hold_valid || (state == ST_LOAD);
    assign accept   = s_valid && s_ready;
    assign sr_pdata = hold_data;
    assign sr_si    = 1'b0;

    always_comb begin
        state_nxt = state;
        sr_load   = 1'b0;
        cs_n      = 1'b1;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (hold_valid && en) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                sr_load   = 1'b1;
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                cs_n = 1'b0;
                if (bit_cnt == '0) state_nxt = (GAP == 0) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt == '0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            hold_data  <= '0;
            hold_valid <= 1'b0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= (state == ST_SHIFT) && (bit_cnt == '0);

            // refill during LOAD takes priority over the clear
            if (accept) begin
                hold_data  <= s_data;
                hold_valid <= 1'b1;
            end else if (state == ST_LOAD) begin
                hold_valid <= 1'b0;
            end

            if (state == ST_LOAD)
                bit_cnt <= CW'(WIDTH - 1);
            else if ((state == ST_SHIFT) && (bit_cnt != '0))
                bit_cnt <= bit_cnt - 1'b1;

            // gap counter is primed throughout SHIFT so it is ready on GAP entry
            if (state == ST_SHIFT)
                gap_cnt <= GAP_LOAD;
            else if ((state == ST_GAP) && (gap_cnt != '0))
                gap_cnt <= gap_cnt - 1'b1;
        end
    end

endmodule
